alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter ENABLE_MUL, default 1, which when 1 enables multi-cycle multiply for OP=110.
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port In_valid, input, 1 bit, which signals that the request is presented.
REQ-005 The block SHALL have port In_ready, output, 1 bit, which signals that the unit can accept a request.
REQ-006 The block SHALL have port InputA, input, 8 bits, operand A.
REQ-007 The block SHALL have port InputB, input, 8 bits, operand B.
REQ-008 The block SHALL have port OP, input, 3 bits, the opcode.
REQ-009 The block SHALL have port SC_in, input, 1 bit, the shift-carry bit inserted by LSH.
REQ-010 The block SHALL have port Out_valid, output, 1 bit, which signals that the result is presented.
REQ-011 The block SHALL have port Out_ready, input, 1 bit, which signals that the consumer accepts the result.
REQ-012 The block SHALL have port Out, output, 8 bits, the result.
REQ-013 The block SHALL have ports Zero, Even, Equal and Err, outputs, 1 bit each, the result flags.

Function
REQ-014 The block SHALL transfer a request only on a rising edge with In_valid=1 and In_ready=1, and SHALL capture InputA, InputB, OP and SC_in on that edge.
REQ-015 The block SHALL transfer a result only on a rising edge with Out_valid=1 and Out_ready=1.
REQ-016 The block SHALL implement FSM states IDLE, EXEC and DONE.
- In_ready=1 only in IDLE.
- Out_valid=1 only in DONE.
REQ-017 On request accept in IDLE, the block SHALL transition as follows:
- OP=110 with ENABLE_MUL=1 -> EXEC.
- All other OP values -> DONE, with the result registered on the accept edge (latency 1 cycle).
REQ-018 The block SHALL decode opcodes as follows, all results modulo 256:
- 000 ADD A+B
- 001 LSH {A[6:0],SC_in}
- 010 RSH {0,A[7:1]}
- 011 XOR A^B
- 100 AND A&B
- 101 SUB A-B
- 110 MUL low byte of A*B
- 111 reserved
REQ-019 The block SHALL discard carry and borrow out of bit 7, with no carry flag.
REQ-020 The block SHALL perform MUL by shift-add, one multiplier bit per cycle, for exactly 8 EXEC cycles using a 3-bit iteration counter.
- After the 8th EXEC cycle it enters DONE.
- Out_valid rises 9 cycles after the accept edge.
REQ-021 Opcode 111, or opcode 110 with ENABLE_MUL=0, SHALL give Out=0 and Err=1 with latency 1; for all other opcodes Err=0.
REQ-022 The block SHALL set the flags as follows:
- Zero=1 iff Out==0.
- Even=1 iff Out[0]==0.
- Equal=1 iff the captured A == the captured B, independent of OP.
REQ-023 In DONE, Out and all flags SHALL stay stable until the output handshake; on the handshake edge the FSM SHALL return to IDLE.
REQ-024 In_ready SHALL be 0 in DONE even when Out_ready=1, so there is no same-cycle accept; maximum throughput is one request per 2 cycles for non-MUL ops.
REQ-025 Input changes while not in IDLE SHALL have no effect.
REQ-026 In_valid deasserted in IDLE SHALL keep the FSM in IDLE with outputs unchanged.

Reset
REQ-027 When Reset_n=0 on a rising edge, the block SHALL enter IDLE and set:
- In_ready=1
- Out_valid=0
- Out=0
- Zero=1
- Even=1
- Equal=0
- Err=0
- MUL accumulator and counter cleared
REQ-028 A reset asserted during EXEC or DONE SHALL abort the operation, discard the result and produce no Out_valid pulse, and the next request after reset SHALL be processed normally.

Verification
REQ-029 The bench SHALL cover ADD A=01, B=01, accepted at cycle t -> at t+1 Out_valid=1, Out=02, Zero=0, Even=1, Equal=1, Err=0.
REQ-030 The bench SHALL cover AND A=04, B=01 -> Out=00, Zero=1, Even=1, Equal=0; Out held stable with Out_ready=0 for 5 cycles, then IDLE one cycle after Out_ready=1.
REQ-031 The bench SHALL cover SUB A=00, B=01 -> Out=FF, Even=0 (borrow wrap), and LSH A=80 with SC_in=1 -> Out=01 (carry-out dropped).
REQ-032 The bench SHALL cover MUL A=13, B=11 with ENABLE_MUL=1 -> Out_valid exactly 9 cycles after accept, Out=43 (0x143 low byte), In_ready=0 throughout EXEC.
REQ-033 The bench SHALL cover OP=111 A=05, B=05 -> Out=00, Err=1, Zero=1, Equal=1, and a second build with ENABLE_MUL=0 where MUL gives Err=1 at latency 1.
REQ-034 The bench SHALL cover Reset_n=0 asserted at the 4th EXEC cycle of MUL -> next edge IDLE, Out_valid=0, Out=00, no result delivered, and a following ADD 02+03 -> Out=05.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - 8-bit ALU with valid/ready handshakes and a shift-add multiplier
module alu_exec_unit #(
  parameter int ENABLE_MUL = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [7:0] InputA,
  input  logic [7:0] InputB,
  input  logic [2:0] OP,
  input  logic       SC_in,
  output logic       Out_valid,
  input  logic       Out_ready,
  output logic [7:0] Out,
  output logic       Zero,
  output logic       Even,
  output logic       Equal,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [2:0] cnt;

  logic [7:0] alu_res;
  logic       alu_err;
  logic       is_mul;
  logic [7:0] acc_next;

  always_comb begin
    alu_res = 8'h00;
    alu_err = 1'b0;
    is_mul  = (OP == 3'b110) && (ENABLE_MUL != 0);
    case (OP)
      3'b000:  alu_res = InputA + InputB;
      3'b001:  alu_res = {InputA[6:0], SC_in};
      3'b010:  alu_res = {1'b0, InputA[7:1]};
      3'b011:  alu_res = InputA ^ InputB;
      3'b100:  alu_res = InputA & InputB;
      3'b101:  alu_res = InputA - InputB;
      // 110 only lands here when the multiplier is compiled out
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : 8'h00);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      In_ready  <= 1'b1;
      Out_valid <= 1'b0;
      Out       <= 8'h00;
      Zero      <= 1'b1;
      Even      <= 1'b1;
      Equal     <= 1'b0;
      Err       <= 1'b0;
      acc       <= 8'h00;
      mcand     <= 8'h00;
      mplier    <= 8'h00;
      cnt       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (In_valid) begin
            Equal    <= (InputA == InputB);
            In_ready <= 1'b0;
            if (is_mul) begin
              acc    <= 8'h00;
              mcand  <= InputA;
              mplier <= InputB;
              cnt    <= 3'd0;
              state  <= EXEC;
            end else begin
              Out       <= alu_res;
              Zero      <= (alu_res == 8'h00);
              Even      <= ~alu_res[0];
              Err       <= alu_err;
              Out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        EXEC: begin
          acc    <= acc_next;
          mcand  <= {mcand[6:0], 1'b0};
          mplier <= {1'b0, mplier[7:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            Out       <= acc_next;
            Zero      <= (acc_next == 8'h00);
            Even      <= ~acc_next[0];
            Err       <= 1'b0;
            Out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (Out_ready) begin
            Out_valid <= 1'b0;
            In_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

  typedef struct {
    logic [7:0] out;
    logic       zero;
    logic       even;
    logic       equal;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, sc_in, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_d;
  logic [2:0] op;
  logic       zero, even, equal, err;

  logic       b_valid, b_in_ready, b_sc, b_out_valid, b_out_ready;
  logic [7:0] b_a, b_b, b_out;
  logic [2:0] b_op;
  logic       b_zero, b_even, b_equal, b_err;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.ENABLE_MUL(1)) dut (
    .Clk(clk), .Reset_n(rst_n), .In_valid(in_valid), .In_ready(in_ready),
    .InputA(in_a), .InputB(in_b), .OP(op), .SC_in(sc_in),
    .Out_valid(out_valid), .Out_ready(out_ready), .Out(out_d),
    .Zero(zero), .Even(even), .Equal(equal), .Err(err)
  );

  alu_exec_unit #(.ENABLE_MUL(0)) dut_nomul (
    .Clk(clk), .Reset_n(rst_n), .In_valid(b_valid), .In_ready(b_in_ready),
    .InputA(b_a), .InputB(b_b), .OP(b_op), .SC_in(b_sc),
    .Out_valid(b_out_valid), .Out_ready(b_out_ready), .Out(b_out),
    .Zero(b_zero), .Even(b_even), .Equal(b_equal), .Err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic z, input logic ev,
                              input logic eq, input logic er, input int lat);
    exp_t e;
    e.out = o; e.zero = z; e.even = ev; e.equal = eq; e.err = er; e.lat = lat;
    return e;
  endfunction

  // Reference model for the randomised part of the run
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] o, input logic sc);
    logic [15:0] prod;
    logic [7:0]  r;
    logic        er;
    int          lat;
    prod = {8'h00, a} * {8'h00, b};
    er = 1'b0;
    lat = 1;
    case (o)
      3'd0: r = 8'(a + b);
      3'd1: r = {a[6:0], sc};
      3'd2: r = a >> 1;
      3'd3: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = 8'(a - b);
      3'd6: begin r = prod[7:0]; lat = 9; end
      default: begin r = 8'h00; er = 1'b1; end
    endcase
    return mk(r, r == 8'h00, ~r[0], a == b, er, lat);
  endfunction

  // Called at posedge+1 with the DUT idle; leaves time at posedge+1 with the DUT idle
  task automatic do_req(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] o, input logic sc, input exp_t e, input int hold);
    exp_t got;
    int   lat;
    logic ir_busy;
    in_a = a; in_b = b; op = o; sc_in = sc; in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); op = 3'($urandom); sc_in = 1'($urandom);
    lat = 1;
    ir_busy = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) ir_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    chk({tag, "_latency"}, lat, got.lat);
    chk({tag, "_in_ready_busy"}, ir_busy | in_ready, 0);
    chk({tag, "_out"}, out_d, got.out);
    chk({tag, "_flags"}, {zero, even, equal, err}, {got.zero, got.even, got.equal, got.err});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (hold > 0) begin
      chk({tag, "_hold_valid"}, {out_valid, in_ready}, 2'b10);
      chk({tag, "_hold_out"}, {out_d, zero, even, equal, err},
          {got.out, got.zero, got.even, got.equal, got.err});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [2:0] ro;
    logic       rs;
    logic       seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 8'h00; in_b = 8'h00; op = 3'd0; sc_in = 1'b0;
    b_valid = 1'b0; b_out_ready = 1'b0; b_a = 8'h00; b_b = 8'h00; b_op = 3'd0; b_sc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hs", {in_ready, out_valid}, 2'b10);
    chk("reset_out", {out_d, zero, even, equal, err}, {8'h00, 4'b1100});
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_hold", {in_ready, out_valid, out_d}, {2'b10, 8'h00});

    do_req("add_01_01", 8'h01, 8'h01, 3'd0, 1'b0, mk(8'h02, 0, 1, 1, 0, 1), 0);
    do_req("and_04_01", 8'h04, 8'h01, 3'd4, 1'b0, mk(8'h00, 1, 1, 0, 0, 1), 5);
    do_req("sub_00_01", 8'h00, 8'h01, 3'd5, 1'b0, mk(8'hFF, 0, 0, 0, 0, 1), 0);
    do_req("lsh_80_sc1", 8'h80, 8'h00, 3'd1, 1'b1, mk(8'h01, 0, 0, 0, 0, 1), 0);
    do_req("rsh_81", 8'h81, 8'h22, 3'd2, 1'b1, mk(8'h40, 0, 1, 0, 0, 1), 0);
    do_req("xor_5a_5a", 8'h5A, 8'h5A, 3'd3, 1'b0, mk(8'h00, 1, 1, 1, 0, 1), 0);
    do_req("mul_13_11", 8'h13, 8'h11, 3'd6, 1'b0, mk(8'h43, 0, 0, 0, 0, 9), 2);
    do_req("rsv_05_05", 8'h05, 8'h05, 3'd7, 1'b0, mk(8'h00, 1, 1, 1, 1, 1), 0);

    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); ro = 3'($urandom); rs = 1'($urandom);
      do_req($sformatf("rnd%0d_op%0d", k, ro), ra, rb, ro, rs, model(ra, rb, ro, rs), k % 3);
    end

    // Abort a multiply in its 4th EXEC cycle
    in_a = 8'h13; in_b = 8'h11; op = 3'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_state", {in_ready, out_valid, out_d}, {2'b10, 8'h00});
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("abort_no_result", seen_valid, 0);
    do_req("add_after_abort", 8'h02, 8'h03, 3'd0, 1'b0, mk(8'h05, 0, 0, 0, 0, 1), 0);

    // Multiplier compiled out: opcode 110 is an error with latency 1
    b_a = 8'h05; b_b = 8'h03; b_op = 3'd6; b_valid = 1'b1;
    chk("nomul_in_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("nomul_valid", b_out_valid, 1);
    chk("nomul_result", {b_out, b_zero, b_even, b_equal, b_err}, {8'h00, 4'b1101});
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("nomul_back_idle", {b_in_ready, b_out_valid}, 2'b10);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
